// File: rtl/sdf_bf_stage.sv
// ============================================================================
// sdf_bf_stage : radix-2 single-path delay-feedback butterfly stage controller
//   Optional feature macro: BF_SAT_EN (saturating butterfly arithmetic)
//   Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module sdf_bf_stage #(
  parameter int WIDTH      = 14,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    out_valid,
  output logic                    out_sof,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic                    primed
);

  localparam int D  = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] c_IDX_B0   = CW'(D);
  localparam logic [CW-1:0] c_IDX_LAST = CW'(2 * D - 1);

  // Wrap by truncation, or clamp when the extra sign bit disagrees.
  function automatic logic [WIDTH-1:0] bf_fit(input logic [WIDTH:0] v);
`ifdef BF_SAT_EN
    if (v[WIDTH] != v[WIDTH-1])
      return v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return v[WIDTH-1:0];
  endfunction

  logic [CW-1:0]           r_cnt;
  logic                    r_primed;
  logic                    r_out_valid;
  logic                    r_out_sof;
  logic signed [WIDTH-1:0] r_out_re;
  logic signed [WIDTH-1:0] r_out_im;
  logic signed [WIDTH-1:0] r_dl_re [D];
  logic signed [WIDTH-1:0] r_dl_im [D];

  logic [CW-1:0]           w_idx;
  logic                    w_phase_b;
  logic                    w_resync;
  logic                    w_primed_eff;
  logic signed [WIDTH-1:0] w_head_re;
  logic signed [WIDTH-1:0] w_head_im;
  logic [WIDTH:0]          w_sum_re_x;
  logic [WIDTH:0]          w_sum_im_x;
  logic [WIDTH:0]          w_dif_re_x;
  logic [WIDTH:0]          w_dif_im_x;
  logic signed [WIDTH-1:0] w_sum_re;
  logic signed [WIDTH-1:0] w_sum_im;
  logic signed [WIDTH-1:0] w_push_re;
  logic signed [WIDTH-1:0] w_push_im;

  // in_sof forces index 0; arriving anywhere else abandons the partial frame.
  assign w_idx        = in_sof ? '0 : r_cnt;
  assign w_phase_b    = w_idx[CW-1];
  assign w_resync     = in_sof && (r_cnt != '0);
  assign w_primed_eff = r_primed && !w_resync;

  assign w_head_re  = r_dl_re[D-1];
  assign w_head_im  = r_dl_im[D-1];
  assign w_sum_re_x = {w_head_re[WIDTH-1], w_head_re} + {in_re[WIDTH-1], in_re};
  assign w_sum_im_x = {w_head_im[WIDTH-1], w_head_im} + {in_im[WIDTH-1], in_im};
  assign w_dif_re_x = {w_head_re[WIDTH-1], w_head_re} - {in_re[WIDTH-1], in_re};
  assign w_dif_im_x = {w_head_im[WIDTH-1], w_head_im} - {in_im[WIDTH-1], in_im};
  assign w_sum_re   = bf_fit(w_sum_re_x);
  assign w_sum_im   = bf_fit(w_sum_im_x);
  assign w_push_re  = w_phase_b ? bf_fit(w_dif_re_x) : in_re;
  assign w_push_im  = w_phase_b ? bf_fit(w_dif_im_x) : in_im;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_primed    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      for (int i = 0; i < D; i++) begin
        r_dl_re[i] <= '0;
        r_dl_im[i] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      if (in_valid) begin
        r_cnt <= w_idx + CW'(1);
        for (int i = 1; i < D; i++) begin
          r_dl_re[i] <= r_dl_re[i-1];
          r_dl_im[i] <= r_dl_im[i-1];
        end
        r_dl_re[0]  <= w_push_re;
        r_dl_im[0]  <= w_push_im;
        r_out_re    <= w_phase_b ? w_sum_re : w_head_re;
        r_out_im    <= w_phase_b ? w_sum_im : w_head_im;
        r_out_valid <= w_phase_b || w_primed_eff;
        r_out_sof   <= (w_idx == c_IDX_B0);
        if (w_idx == c_IDX_LAST)
          r_primed <= 1'b1;
        else if (w_resync)
          r_primed <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign primed    = r_primed;

endmodule

`default_nettype wire

// File: doc/sdf_bf_stage.md
# sdf_bf_stage

Radix-2 single-path delay-feedback (SDF) stage controller for the 64-point FFT. It sequences one shared butterfly (sum/difference) against a delay line so a serial complex sample stream of 2·D samples per frame is processed at one sample per valid cycle. Stages are cascaded with decreasing D (32, 16, … 1). Twiddle multiplication is handled downstream and is not part of this block.

## Interface
- WIDTH, 14, bit width of each real/imag component (two's complement)
- DEPTH_LOG2, 5, log2 of delay length D (D = 2^DEPTH_LOG2; 5 gives the first stage of a 64-point FFT)

Clocking: one clock; reset is synchronous and active-high.

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input sample present this cycle
- in_sof  in  1  qualifies in_valid: this sample is index 0 of a frame
- in_re  in  WIDTH  input real part
- in_im  in  WIDTH  input imag part
- out_valid  out  1  output sample valid
- out_sof  out  1  first output sample of a frame (first butterfly sum)
- out_re  out  WIDTH  output real part
- out_im  out  WIDTH  output imag part
- primed  out  1  delay line holds a complete set of pending differences

## Operation
- Frame counter cnt, DEPTH_LOG2+1 bits, advances by 1 on every in_valid and wraps at 2·D. Phase A: cnt MSB = 0. Phase B: cnt MSB = 1.
- in_valid with in_sof forces the sample to index 0 (cnt treated as 0, next value 1).
- Delay line: D-entry complex shift register. Advances only on in_valid and never shifts without it. Head = oldest entry.
- Phase A, per accepted sample: push the input. Output = head, which is the difference from the previous frame.
- Phase B, per accepted sample x1 with head x0:
  - output sum = x0 + x1
  - push difference = x0 − x1
- Arithmetic: full-width add/sub truncated to WIDTH bits (wrap), unless BF_SAT_EN is defined. No scaling.
- primed:
  - set when cnt wraps from 2·D−1 to 0, i.e. a full phase B has completed
  - cleared by rst
  - cleared by in_sof arriving when cnt ≠ 0 (resync mid-frame)
- out_valid:
  - phase B accepted samples: always 1
  - phase A accepted samples: equal to primed
  - no in_valid: 0
- out_sof = 1 on the output for index D, the first phase-B sample.
- No backpressure. The downstream stage must accept every out_valid cycle.

## Timing
- Reset values: out_valid 0, out_sof 0, out_re 0, out_im 0, primed 0, cnt 0, delay line all zero.
- All outputs are registered. The response to a sample accepted in cycle t appears in cycle t+1.
- Latency:
  - sum of pair (n, n+D): 1 cycle after sample n+D is accepted
  - difference of that pair: emitted D accepted samples later, during the next frame's phase A
- Gaps in in_valid stall the stage. State is held, and out_valid = 0 in the cycle after each gap cycle.
- Mid-frame in_sof:
  - partial frame is abandoned; stale delay entries are overwritten by the new phase A
  - no out_valid until phase B of the new frame
- rst asserted mid-frame takes priority over in_valid. All state returns to reset values in the next cycle.
- Draining pending differences requires D further in_valid samples, which may be zeros.

## Configuration
- BF_SAT_EN
  - defined: sum and difference saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1] per component
  - undefined: two's-complement wrap
- Affects only the butterfly arithmetic. Control and timing are identical in both builds.

## Test plan
Unless stated otherwise: DEPTH_LOG2=2 (D=4), WIDTH=14, im = 0.

1. Reset: hold rst 3 cycles with in_valid=1 toggling → all outputs 0 and primed 0 throughout, plus the cycle after release.
2. Single frame: in_re = 1..8 contiguous, sof on sample 1 → out_valid only for samples 5–8, with out_re = 6, 8, 10, 12 and out_sof on the 6. Then a second frame of 8 zeros → first four outputs −4, −4, −4, −4 with out_valid=1 and primed=1, followed by sums 0.
3. Stall: same stimulus as scenario 2 with in_valid low every other cycle → identical output value sequence, out_valid only the cycle after each accepted sample.
4. Resync: sof at sample 3 of a frame, then a clean 8-sample frame → primed drops, no out_valid during the new phase A, and sums are correct in the new phase B.
5. Overflow: in_re = 8191 at index 0 and 1 at index D.
   - sum: 8191 with BF_SAT_EN defined, −8192 without
   - difference: 8190 in both builds
6. Reset mid-frame: assert rst after sample 6 → next cycle all outputs 0 and primed 0. A fresh frame then behaves exactly as in scenario 2.
